// File: rtl/pwm_pkg.sv
// Shared types and arithmetic for the PWM control stages.
package pwm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RAMP_UP,
        HOLD_HIGH,
        RAMP_DOWN,
        HOLD_LOW
    } fade_state_t;

    // 32-bit working width leaves headroom for any duty+step sum, so the
    // up direction saturates at max_duty and the down direction floors at 0.
    function automatic logic [31:0] sat_step(input logic [31:0] duty,
                                             input logic [31:0] step,
                                             input logic [31:0] max_duty,
                                             input logic        up);
        logic [31:0] r;
        if (up) begin
            r = duty + step;
            if (r > max_duty) r = max_duty;
        end else begin
            r = (duty <= step) ? 32'd0 : duty - step;
        end
        return r;
    endfunction

endpackage

// File: rtl/pwm_tick_divider.sv
// Divides the generator's period_end ticks down to a step strobe.
module pwm_tick_divider #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             period_end,
    input  logic             clear,
    input  logic [DIV_W-1:0] div_count,
    output logic             step_strobe
);

    logic [DIV_W-1:0] cnt_q, cnt_d, last;

    // A divide count of 0 behaves as 1 (strobe on every tick).
    assign last        = (div_count == '0) ? '0 : div_count - DIV_W'(1);
    assign step_strobe = period_end && (cnt_q >= last);

    always_comb begin
        cnt_d = cnt_q;
        if (clear)            cnt_d = '0;
        else if (step_strobe) cnt_d = '0;
        else if (period_end)  cnt_d = cnt_q + DIV_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

endmodule

// File: rtl/pwm_fade_sequencer.sv
// Breathing envelope: ramp up, hold, ramp down, hold, repeat; every duty
// change is issued as a one-cycle update aligned to the generator's period_end.
module pwm_fade_sequencer
    import pwm_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MAX_DUTY = 256,
    parameter int HOLD_W   = 8,
    parameter int DIV_W    = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [WIDTH-1:0]  step,
    input  logic [DIV_W-1:0]  periods_per_step,
    input  logic [HOLD_W-1:0] hold_high,
    input  logic [HOLD_W-1:0] hold_low,
    input  logic              period_end,
    output logic [WIDTH:0]    pwm_duty_cycle,
    output logic              update_parameters,
    output logic              busy,
    output logic              loop_done
);

    localparam logic [WIDTH:0] MAX_D = (WIDTH+1)'(MAX_DUTY);

    fade_state_t       state_q, state_d;
    logic [WIDTH:0]    duty_q, duty_d, up_duty, dn_duty;
    logic              upd_q, upd_d, done_q, done_d;
    logic [WIDTH-1:0]  step_q, step_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [HOLD_W-1:0] hh_q, hh_d, hl_q, hl_d, hcnt_q, hcnt_d;
    logic              latch, strobe, div_clr;

    assign div_clr = (state_d != state_q);

    pwm_tick_divider #(.DIV_W(DIV_W)) u_div (
        .clk         (clk),
        .reset_n     (reset_n),
        .period_end  (period_end),
        .clear       (div_clr),
        .div_count   (div_q),
        .step_strobe (strobe)
    );

    assign up_duty = (WIDTH+1)'(sat_step(32'(duty_q), 32'(step_q), 32'(MAX_DUTY), 1'b1));
    assign dn_duty = (WIDTH+1)'(sat_step(32'(duty_q), 32'(step_q), 32'(MAX_DUTY), 1'b0));

    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        upd_d   = 1'b0;
        done_d  = 1'b0;
        hcnt_d  = hcnt_q;
        latch   = 1'b0;
        step_d  = step_q;
        div_d   = div_q;
        hh_d    = hh_q;
        hl_d    = hl_q;
        case (state_q)
            IDLE: if (enable) begin
                state_d = RAMP_UP;
                latch   = 1'b1;
            end
            RAMP_UP: if (strobe) begin
                duty_d = up_duty;
                upd_d  = 1'b1;
                if (up_duty == MAX_D) state_d = (hh_q != '0) ? HOLD_HIGH : RAMP_DOWN;
            end
            HOLD_HIGH: if (period_end) begin
                if (hcnt_q == hh_q - HOLD_W'(1)) state_d = RAMP_DOWN;
                else                             hcnt_d  = hcnt_q + HOLD_W'(1);
            end
            RAMP_DOWN: if (strobe) begin
                duty_d = dn_duty;
                upd_d  = 1'b1;
                if (dn_duty == '0) begin
                    if (hl_q != '0) begin
                        state_d = HOLD_LOW;
                    end else begin
                        state_d = RAMP_UP;
                        done_d  = 1'b1;
                        latch   = 1'b1;
                    end
                end
            end
            HOLD_LOW: if (period_end) begin
                if (hcnt_q == hl_q - HOLD_W'(1)) begin
                    state_d = RAMP_UP;
                    done_d  = 1'b1;
                    latch   = 1'b1;
                end else begin
                    hcnt_d = hcnt_q + HOLD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        // A dropped enable overrides whatever the loop would have done this tick.
        if (state_q != IDLE && period_end && !enable) begin
            state_d = IDLE;
            duty_d  = '0;
            upd_d   = 1'b1;
            done_d  = 1'b0;
            latch   = 1'b0;
        end
        if (state_d != state_q) hcnt_d = '0;
        if (latch) begin
            step_d = (step == '0) ? WIDTH'(1) : step;
            div_d  = (periods_per_step == '0) ? DIV_W'(1) : periods_per_step;
            hh_d   = hold_high;
            hl_d   = hold_low;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            duty_q  <= '0;
            upd_q   <= 1'b0;
            done_q  <= 1'b0;
            hcnt_q  <= '0;
            step_q  <= '0;
            div_q   <= '0;
            hh_q    <= '0;
            hl_q    <= '0;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            upd_q   <= upd_d;
            done_q  <= done_d;
            hcnt_q  <= hcnt_d;
            step_q  <= step_d;
            div_q   <= div_d;
            hh_q    <= hh_d;
            hl_q    <= hl_d;
        end
    end

    assign pwm_duty_cycle    = duty_q;
    assign update_parameters = upd_q;
    assign loop_done         = done_q;
    assign busy              = (state_q != IDLE);

endmodule

// File: tb/tb_pwm_fade_sequencer.sv
// Bench for pwm_fade_sequencer: per-tick schedule model plus directed literal checks.
module tb_pwm_fade_sequencer;

    localparam int WIDTH = 8, MAX_DUTY = 256, HOLD_W = 8, DIV_W = 8;

    logic clk = 1'b0, reset_n = 1'b0, enable = 1'b0, period_end = 1'b0;
    logic [WIDTH-1:0] step = '0;
    logic [DIV_W-1:0] pps = '0;
    logic [HOLD_W-1:0] hh = '0, hl = '0;
    logic [WIDTH:0] pwm_duty_cycle;
    logic update_parameters, busy, loop_done;

    always #5 clk = ~clk;

    pwm_fade_sequencer #(.WIDTH(WIDTH), .MAX_DUTY(MAX_DUTY), .HOLD_W(HOLD_W), .DIV_W(DIV_W)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .step(step),
        .periods_per_step(pps), .hold_high(hh), .hold_low(hl),
        .period_end(period_end), .pwm_duty_cycle(pwm_duty_cycle),
        .update_parameters(update_parameters), .busy(busy), .loop_done(loop_done)
    );

    int checks = 0, errors = 0, cyc = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // period_end source: fixed period or random
    int pe_per = 4, pe_cnt = 0;
    bit pe_rand = 0;
    always @(negedge clk) begin
        if (pe_rand) period_end = ($urandom_range(0, 2) == 0);
        else begin
            pe_cnt     = (pe_cnt + 1 >= pe_per) ? 0 : pe_cnt + 1;
            period_end = (pe_cnt == 0);
        end
    end

    // Model: one loop is a list of per-tick outcomes built from the latched config.
    typedef struct { bit upd; int duty; bit done; } ev_t;
    ev_t sched[$];
    bit m_busy = 0, m_upd = 0, m_done = 0;
    int m_duty = 0;

    function automatic int eff(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    task automatic build();
        int s, dv, d;
        ev_t e;
        s = eff(int'(step)); dv = eff(int'(pps)); d = 0;
        sched.delete();
        while (d < MAX_DUTY) begin
            repeat (dv - 1) sched.push_back('{0, d, 0});
            d = (d + s > MAX_DUTY) ? MAX_DUTY : d + s;
            sched.push_back('{1, d, 0});
        end
        repeat (int'(hh)) sched.push_back('{0, d, 0});
        while (d > 0) begin
            repeat (dv - 1) sched.push_back('{0, d, 0});
            d = (d <= s) ? 0 : d - s;
            sched.push_back('{1, d, 0});
        end
        repeat (int'(hl)) sched.push_back('{0, d, 0});
        e = sched.pop_back();
        e.done = 1;
        sched.push_back(e);
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_busy = 0; m_duty = 0; m_upd = 0; m_done = 0;
            sched.delete();
        end else begin
            m_upd = 0; m_done = 0;
            if (!m_busy) begin
                if (enable) begin build(); m_busy = 1; end
            end else if (period_end) begin
                if (!enable) begin
                    m_busy = 0; m_duty = 0; m_upd = 1;
                    sched.delete();
                end else begin
                    ev_t e;
                    e = sched.pop_front();
                    if (e.upd) begin m_duty = e.duty; m_upd = 1; end
                    m_done = e.done;
                    if (sched.size() == 0) build();
                end
            end
        end
    end

    bit cmp_en = 0;
    always @(negedge clk) if (cmp_en) begin
        chk("duty", int'(pwm_duty_cycle), m_duty);
        chk("update", int'(update_parameters), int'(m_upd));
        chk("busy", int'(busy), int'(m_busy));
        chk("loop_done", int'(loop_done), int'(m_done));
    end

    // Update log for directed expectations
    int log_d[$], log_cyc[$];
    bit log_done[$], log_pe[$], log_busy[$];
    always @(posedge clk) cyc++;
    always @(posedge clk) begin
        #1;
        if (update_parameters) begin
            log_d.push_back(int'(pwm_duty_cycle));
            log_done.push_back(loop_done);
            log_pe.push_back(period_end);
            log_busy.push_back(busy);
            log_cyc.push_back(cyc);
        end
    end

    task automatic clear_log();
        log_d.delete(); log_done.delete(); log_pe.delete(); log_busy.delete(); log_cyc.delete();
    endtask

    task automatic wait_upd(input int n, input int budget, input string name);
        int c = 0;
        while (log_d.size() < n && c < budget) begin @(negedge clk); c++; end
        if (log_d.size() < n) chk({name, " timeout"}, log_d.size(), n);
    endtask

    task automatic cfg(input int s, input int d, input int h1, input int h2);
        step = WIDTH'(s); pps = DIV_W'(d); hh = HOLD_W'(h1); hl = HOLD_W'(h2);
    endtask

    task automatic go_idle();
        int c = 0;
        enable = 0;
        while (busy && c < 200) begin @(negedge clk); c++; end
        if (busy) chk("go_idle timeout", int'(busy), 0);
        @(negedge clk);
        clear_log();
    endtask

    initial begin
        int e1[9] = '{64, 128, 192, 256, 192, 128, 64, 0, 64};
        int e2[6] = '{100, 200, 256, 156, 56, 0};
        int e3[4] = '{128, 256, 128, 0};
        repeat (3) @(negedge clk);
        cmp_en = 1;
        chk("reset duty", int'(pwm_duty_cycle), 0);
        chk("reset update", int'(update_parameters), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset loop_done", int'(loop_done), 0);
        reset_n = 1;

        // basic loop, step 64
        cfg(64, 1, 0, 0); enable = 1;
        wait_upd(9, 200, "t1");
        for (int i = 0; i < 9; i++) begin
            chk("t1 duty", log_d[i], e1[i]);
            chk("t1 loop_done", int'(log_done[i]), (i == 7) ? 1 : 0);
            chk("t1 update after tick", int'(log_pe[i]), 1);
        end
        go_idle();

        // saturation both ways
        cfg(100, 1, 0, 0); enable = 1;
        wait_upd(6, 200, "t2");
        for (int i = 0; i < 6; i++) chk("t2 duty", log_d[i], e2[i]);
        go_idle();

        // divider and high hold
        cfg(128, 3, 2, 0); enable = 1;
        wait_upd(4, 400, "t3");
        for (int i = 0; i < 4; i++) chk("t3 duty", log_d[i], e3[i]);
        chk("t3 step gap", log_cyc[1] - log_cyc[0], 12);
        chk("t3 hold gap", log_cyc[2] - log_cyc[1], 20);
        go_idle();

        // zero step/div treated as 1, tick every cycle
        pe_per = 1;
        cfg(0, 0, 0, 0); enable = 1;
        wait_upd(3, 50, "t4");
        for (int i = 0; i < 3; i++) chk("t4 duty", log_d[i], i + 1);
        chk("t4 consecutive", log_cyc[1] - log_cyc[0], 1);
        go_idle();
        pe_per = 4;

        // enable drop during ramp down at 128
        cfg(64, 1, 0, 0); enable = 1;
        wait_upd(6, 200, "t5");
        chk("t5 pre-drop duty", log_d[5], 128);
        enable = 0;
        wait_upd(7, 50, "t5 drop");
        chk("t5 drop duty", log_d[6], 0);
        chk("t5 drop busy", int'(log_busy[6]), 0);
        @(negedge clk);
        clear_log(); enable = 1;
        wait_upd(1, 50, "t5 restart");
        chk("t5 restart duty", log_d[0], 64);
        go_idle();

        // async reset mid HOLD_HIGH
        cfg(128, 1, 10, 0); enable = 1;
        wait_upd(2, 100, "t6");
        repeat (2) @(negedge clk);
        @(posedge clk); #2;
        reset_n = 0;
        #1;
        chk("t6 async duty", int'(pwm_duty_cycle), 0);
        chk("t6 async busy", int'(busy), 0);
        chk("t6 async update", int'(update_parameters), 0);
        @(negedge clk);
        clear_log(); reset_n = 1;
        wait_upd(1, 100, "t6 restart");
        chk("t6 restart duty", log_d[0], 128);

        // randomized phase, model checks every cycle
        pe_rand = 1;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (i == 2500) begin pe_rand = 0; pe_per = 1; end
            if (i == 3200) pe_per = $urandom_range(2, 5);
            if ($urandom_range(0, 39) == 0)
                cfg(($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(32, 255),
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
            if ($urandom_range(0, 149) == 0) enable = ~enable;
            else if ($urandom_range(0, 99) == 0 && enable) begin
                enable = 0; @(negedge clk); enable = 1;
            end
        end
        enable = 0;
        repeat (20) @(negedge clk);
        cmp_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

endmodule
